// File: rtl/ps2_digit_sender.sv
// PS/2 device-side transmitter: sends a decimal digit as a set-2 key press/release
// (make code, F0, make code) on an emulated PS/2 clock/data pair.
module ps2_digit_sender #(
    parameter int HALF_PERIOD = 2500,
    parameter int GAP_CYCLES  = 5000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    output logic       ready_out,
    output logic       ps2_clk_out,
    output logic       ps2_data_out,
    output logic       done_out,
    output logic       err_out
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BIT_HI = 3'd1;
    localparam logic [2:0] BIT_LO = 3'd2;
    localparam logic [2:0] GAP    = 3'd3;
    localparam logic [2:0] FINISH = 3'd4;

    localparam logic [15:0] HALF_LOAD  = 16'(HALF_PERIOD - 1);
    localparam logic [15:0] GAP_LOAD   = 16'(GAP_CYCLES - 1);
    localparam logic [3:0]  LAST_BIT   = 4'd10;
    localparam logic [1:0]  LAST_FRAME = 2'd2;
    localparam logic [7:0]  BREAK_CODE = 8'hF0;
    localparam logic [3:0]  MAX_DIGIT  = 4'd9;

    logic [2:0]  state;
    logic [15:0] timer;
    logic [3:0]  bit_idx;
    logic [1:0]  frame_idx;
    logic [7:0]  code;
    logic [10:0] frame_sh;   // remaining bits of the current frame, next-to-send at [1]
    logic        clk_q;
    logic        data_q;
    logic        err_q;

    function automatic logic [7:0] scan_code(input logic [3:0] d);
        logic [7:0] sc;
        sc = 8'h00;
        case (d)
            4'd0: sc = 8'h45;
            4'd1: sc = 8'h16;
            4'd2: sc = 8'h1E;
            4'd3: sc = 8'h26;
            4'd4: sc = 8'h25;
            4'd5: sc = 8'h2E;
            4'd6: sc = 8'h36;
            4'd7: sc = 8'h3D;
            4'd8: sc = 8'h3E;
            4'd9: sc = 8'h46;
            default: sc = 8'h00;
        endcase
        return sc;
    endfunction

    // Stop, odd parity, data LSB-first, start.
    function automatic logic [10:0] build_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

    // NOTE: every register in this block uses <= so all updates see the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            timer     <= '0;
            bit_idx   <= '0;
            frame_idx <= '0;
            code      <= '0;
            frame_sh  <= '1;
            clk_q     <= 1'b1;
            data_q    <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state)
                IDLE, FINISH: begin
                    state <= IDLE;
                    if (digit_valid) begin
                        if (digit_in <= MAX_DIGIT) begin
                            code      <= scan_code(digit_in);
                            frame_sh  <= build_frame(scan_code(digit_in));
                            bit_idx   <= '0;
                            frame_idx <= '0;
                            timer     <= HALF_LOAD;
                            state     <= BIT_HI;
                            clk_q     <= 1'b1;
                            data_q    <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end

                BIT_HI: begin
                    if (timer == '0) begin
                        state <= BIT_LO;
                        timer <= HALF_LOAD;
                        clk_q <= 1'b0;
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                BIT_LO: begin
                    if (timer == '0) begin
                        clk_q <= 1'b1;
                        if (bit_idx == LAST_BIT) begin
                            data_q <= 1'b1;
                            if (frame_idx == LAST_FRAME) begin
                                state <= FINISH;
                            end else begin
                                state     <= GAP;
                                timer     <= GAP_LOAD;
                                frame_idx <= frame_idx + 2'd1;
                            end
                        end else begin
                            // Data only moves together with the rising clock.
                            state    <= BIT_HI;
                            timer    <= HALF_LOAD;
                            bit_idx  <= bit_idx + 4'd1;
                            data_q   <= frame_sh[1];
                            frame_sh <= {1'b1, frame_sh[10:1]};
                        end
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                GAP: begin
                    if (timer == '0) begin
                        state    <= BIT_HI;
                        timer    <= HALF_LOAD;
                        bit_idx  <= '0;
                        data_q   <= 1'b0;
                        frame_sh <= build_frame((frame_idx == 2'd1) ? BREAK_CODE : code);
                    end else begin
                        timer <= timer - 16'd1;
                    end
                end

                default: begin
                    state  <= IDLE;
                    clk_q  <= 1'b1;
                    data_q <= 1'b1;
                end
            endcase
        end
    end

    // FINISH doubles as an accepting state so back-to-back events have no dead cycle.
    assign ready_out    = (state == IDLE) || (state == FINISH);
    assign done_out     = (state == FINISH);
    assign err_out      = err_q;
    assign ps2_clk_out  = clk_q;
    assign ps2_data_out = data_q;

endmodule

// File: tb/tb_ps2_digit_sender.sv
// Directed bench for ps2_digit_sender: frame decoding receiver, protocol timing
// monitor, and table-driven digit events plus back-to-back, reset and busy cases.
module tb_ps2_digit_sender;

    localparam int HP  = 4;
    localparam int GAP = 8;
    localparam int EVENT_CYCLES = 3 * 22 * HP + 2 * GAP + 1;   // accept edge to done sample

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] digit_in;
    logic       digit_valid;
    logic       ready_out, ps2_clk_out, ps2_data_out, done_out, err_out;

    ps2_digit_sender #(.HALF_PERIOD(HP), .GAP_CYCLES(GAP)) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_in    (digit_in),
        .digit_valid (digit_valid),
        .ready_out   (ready_out),
        .ps2_clk_out (ps2_clk_out),
        .ps2_data_out(ps2_data_out),
        .done_out    (done_out),
        .err_out     (err_out)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    typedef struct {
        logic [3:0] digit;
        logic [7:0] code;
        logic       err;
    } vec_t;

    vec_t vecs[12];

    function automatic int decode(input logic [7:0] c);
        for (int i = 0; i < 10; i++)
            if (vecs[i].code == c) return i;
        return -1;
    endfunction

    // ---------------- receiver / protocol monitor ----------------
    logic [7:0]  rx_q[$];
    logic [10:0] rx_sh    = '0;
    int          rx_bits  = 0;
    logic        prev_clk = 1'b1;
    logic        prev_data = 1'b1;
    int          hi_len   = 0;
    int          lo_len   = 0;
    int          done_cnt = 0;
    int          err_cnt  = 0;

    always @(negedge clk) begin
        if (rst) begin
            rx_bits   = 0;
            hi_len    = 0;
            lo_len    = 0;
            prev_clk  = 1'b1;
            prev_data = 1'b1;
        end else begin
            if (done_out || err_out) check("done_err_exclusive", 32'(done_out & err_out), 0);
            done_cnt += int'(done_out);
            err_cnt  += int'(err_out);
            if (!prev_clk && !ps2_clk_out)
                check("data_stable_clk_low", 32'(ps2_data_out), 32'(prev_data));
            if (prev_clk && !ps2_clk_out) begin
                check("clk_high_phase_len", hi_len, HP);
                lo_len  = 1;
                rx_sh   = {ps2_data_out, rx_sh[10:1]};
                rx_bits = rx_bits + 1;
                if (rx_bits == 11) begin
                    check("frame_start_bit", 32'(rx_sh[0]), 0);
                    check("frame_stop_bit", 32'(rx_sh[10]), 1);
                    check("frame_odd_parity", 32'(^rx_sh[9:1]), 1);
                    rx_q.push_back(rx_sh[8:1]);
                    rx_bits = 0;
                end
            end else if (!prev_clk && ps2_clk_out) begin
                check("clk_low_phase_len", lo_len, HP);
                hi_len = 1;
            end else if (ps2_clk_out) begin
                if (rx_bits == 0 && prev_data && !ps2_data_out) hi_len = 1;
                else hi_len = hi_len + 1;
            end else begin
                lo_len = lo_len + 1;
            end
            prev_clk  = ps2_clk_out;
            prev_data = ps2_data_out;
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done(input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_out && n < budget);
        check("done_within_budget", 32'(done_out), 1);
    endtask

    task automatic check_event(input string tag, input int digit, input logic [7:0] c);
        check({tag, "_frame_count"}, rx_q.size(), 3);
        if (rx_q.size() == 3) begin
            check({tag, "_make"}, rx_q[0], c);
            check({tag, "_break"}, rx_q[1], 8'hF0);
            check({tag, "_make2"}, rx_q[2], c);
            check({tag, "_decoded_digit"}, decode(rx_q[2]), digit);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int n, total, d0, e0, bad;

        vecs[0]  = '{4'd0, 8'h45, 1'b0};
        vecs[1]  = '{4'd1, 8'h16, 1'b0};
        vecs[2]  = '{4'd2, 8'h1E, 1'b0};
        vecs[3]  = '{4'd3, 8'h26, 1'b0};
        vecs[4]  = '{4'd4, 8'h25, 1'b0};
        vecs[5]  = '{4'd5, 8'h2E, 1'b0};
        vecs[6]  = '{4'd6, 8'h36, 1'b0};
        vecs[7]  = '{4'd7, 8'h3D, 1'b0};
        vecs[8]  = '{4'd8, 8'h3E, 1'b0};
        vecs[9]  = '{4'd9, 8'h46, 1'b0};
        vecs[10] = '{4'hC, 8'h00, 1'b1};
        vecs[11] = '{4'hF, 8'h00, 1'b1};

        rst = 1'b1;
        digit_in = 4'd0;
        digit_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_out), 1);
        check("rst_ps2_clk", 32'(ps2_clk_out), 1);
        check("rst_ps2_data", 32'(ps2_data_out), 1);
        check("rst_done", 32'(done_out), 0);
        check("rst_err", 32'(err_out), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Cycle-exact timing of one event, digit 1.
        rx_q.delete();
        digit_in = 4'd1;
        digit_valid = 1'b1;
        check("t1_ready_before", 32'(ready_out), 1);
        for (int c = 1; c <= 282; c++) begin
            @(negedge clk);
            if (c == 1) begin
                digit_valid = 1'b0;
                check("t1_c1_ready", 32'(ready_out), 0);
                check("t1_c1_clk", 32'(ps2_clk_out), 1);
                check("t1_c1_start_bit", 32'(ps2_data_out), 0);
            end
            if (c == 4) check("t1_c4_clk", 32'(ps2_clk_out), 1);
            if (c == 5) check("t1_c5_clk", 32'(ps2_clk_out), 0);
            if (c == 8) check("t1_c8_clk", 32'(ps2_clk_out), 0);
            if (c == 9) check("t1_c9_clk", 32'(ps2_clk_out), 1);
            if (c == 13) check("t1_c13_clk", 32'(ps2_clk_out), 0);
            if (c == 90) check("t1_gap_lines", 32'({ps2_clk_out, ps2_data_out}), 32'b11);
            if (c == 280) check("t1_c280_done", 32'(done_out), 0);
            if (c == 281) begin
                check("t1_c281_done", 32'(done_out), 1);
                check("t1_c281_ready", 32'(ready_out), 1);
                check("t1_c281_lines", 32'({ps2_clk_out, ps2_data_out}), 32'b11);
            end
            if (c == 282) check("t1_c282_done", 32'(done_out), 0);
        end
        check_event("t1", 1, 8'h16);

        // Table-driven single events, including rejected digits.
        foreach (vecs[i]) begin
            rx_q.delete();
            d0 = done_cnt;
            e0 = err_cnt;
            digit_in = vecs[i].digit;
            digit_valid = 1'b1;
            @(negedge clk);
            digit_valid = 1'b0;
            if (vecs[i].err) begin
                check("err_pulse", 32'(err_out), 1);
                check("err_ready", 32'(ready_out), 1);
                bad = 0;
                for (int k = 0; k < 50; k++) begin
                    @(negedge clk);
                    if (!ps2_clk_out || !ps2_data_out || !ready_out || err_out || done_out) bad++;
                end
                check("err_idle_50_cycles", bad, 0);
                check("err_count", err_cnt - e0, 1);
                check("err_no_done", done_cnt - d0, 0);
                check("err_no_frames", rx_q.size(), 0);
            end else begin
                check("vec_err_low", 32'(err_out), 0);
                wait_done(400, n);
                check("vec_latency", n, EVENT_CYCLES - 1);
                @(negedge clk);
                check_event("vec", int'(vecs[i].digit), vecs[i].code);
                check("vec_done_count", done_cnt - d0, 1);
                check("vec_no_err", err_cnt - e0, 0);
            end
            repeat (3) @(negedge clk);
        end

        // Back-to-back sweep 0..9 with valid held high.
        rx_q.delete();
        d0 = done_cnt;
        total = 0;
        digit_in = vecs[0].digit;
        digit_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            wait_done(400, n);
            check("b2b_event_len", n, EVENT_CYCLES);
            total += n;
            if (k < 9) digit_in = vecs[k + 1].digit;
            else digit_valid = 1'b0;
        end
        @(negedge clk);
        check("b2b_total_cycles", total, 10 * EVENT_CYCLES);
        check("b2b_done_count", done_cnt - d0, 10);
        check("b2b_frame_count", rx_q.size(), 30);
        if (rx_q.size() == 30)
            for (int k = 0; k < 10; k++) begin
                check("b2b_make", rx_q[3 * k], vecs[k].code);
                check("b2b_break", rx_q[3 * k + 1], 8'hF0);
                check("b2b_decoded", decode(rx_q[3 * k + 2]), k);
            end
        repeat (3) @(negedge clk);

        // Requests while busy are ignored.
        rx_q.delete();
        e0 = err_cnt;
        digit_in = 4'd5;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        repeat (48) @(negedge clk);
        digit_in = 4'hC;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        repeat (100) @(negedge clk);
        digit_in = 4'd2;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        digit_in = 4'd0;
        wait_done(400, n);
        check("busy_latency", n, EVENT_CYCLES - 151);
        @(negedge clk);
        check_event("busy", 5, 8'h2E);
        check("busy_no_err", err_cnt - e0, 0);
        repeat (3) @(negedge clk);

        // Reset during bit 5 of the F0 frame, then a clean digit 7.
        rx_q.delete();
        d0 = done_cnt;
        digit_in = 4'd3;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        repeat (138) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_lines", 32'({ps2_clk_out, ps2_data_out}), 32'b11);
        check("rstmid_ready", 32'(ready_out), 1);
        check("rstmid_done", 32'(done_out), 0);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_first_frame_only", rx_q.size(), 1);
        rx_q.delete();
        repeat (5) @(negedge clk);
        check("rstmid_no_done", done_cnt - d0, 0);
        digit_in = 4'd7;
        digit_valid = 1'b1;
        @(negedge clk);
        digit_valid = 1'b0;
        wait_done(400, n);
        check("rstmid_latency", n, EVENT_CYCLES - 1);
        @(negedge clk);
        check_event("rstmid", 7, 8'h3D);
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ps2_digit_sender.md
Name: ps2_digit_sender

Overview:
- Device-side PS/2 keyboard emulator: the transmit end of the keyboard path.
- Takes a decimal digit (0-9), maps it to its set-2 make scan code, and serialises a full key press/release as three PS/2 frames: make code, 8'hF0, make code.
- Drives PS/2 clock and data toward the keyboard receiver/decoder chain.
- Used for loopback testing on the board and as the stimulus model for the keyboard benches.

Parameters:
- HALF_PERIOD, 2500, system-clock cycles per PS/2 clock half-period (100 MHz -> 20 kHz PS/2 clock); legal range 2..65535.
- GAP_CYCLES, 5000, idle cycles (both lines high) between consecutive frames of one key event; legal range 1..65535.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- digit_in  in  4  binary digit to send; only 0..9 are legal.
- digit_valid  in  1  request; sampled only while ready_out=1.
- ready_out  out  1  high when idle and able to accept a request.
- ps2_clk_out  out  1  PS/2 clock toward receiver; idle high.
- ps2_data_out  out  1  PS/2 data toward receiver; idle high.
- done_out  out  1  one-cycle pulse when the full 3-frame event has been sent.
- err_out  out  1  one-cycle pulse when a request with digit_in > 9 is rejected.

Behaviour:
- Reset values (rst=1 at an edge): ready_out=1, ps2_clk_out=1, ps2_data_out=1, done_out=0, err_out=0; FSM IDLE; all counters 0.
- Reset mid-transfer aborts immediately: lines high on the next cycle, no done_out.
- Scan-code LUT: 0->45, 1->16, 2->1E, 3->26, 4->25, 5->2E, 6->36, 7->3D, 8->3E, 9->46 (hex).
- Accept: on an edge with ready_out=1 and digit_valid=1:
  - digit_in <= 9: latch the code, ready_out=0 from the next cycle.
  - digit_in > 9: err_out=1 for exactly the next cycle, ready_out stays 1, lines stay idle.
- While busy, digit_valid and digit_in are ignored.
- Frame format, 11 bits: start 0, data[0]..data[7] LSB first, odd parity (~^data), stop 1.
- Bit timing: each bit lasts 2*HALF_PERIOD cycles.
  - First HALF_PERIOD cycles: ps2_clk_out=1, ps2_data_out=bit value. Data changes only on the cycle clock is/goes high.
  - Next HALF_PERIOD cycles: ps2_clk_out=0, data held.
  - The receiver samples on the falling edge, so data is stable for HALF_PERIOD cycles around each falling edge.
- FSM states: IDLE -> BIT_HI -> BIT_LO -> (next bit: BIT_HI | frame end: GAP or FINISH) ; GAP -> BIT_HI of next frame ; FINISH -> IDLE.
- Frame sequence: frame_idx 0 = code, 1 = 8'hF0, 2 = code.
  - GAP_CYCLES idle cycles (both lines 1) follow frames 0 and 1 only.
- Timing reference: accept edge = cycle 0; the first start-bit cycle is cycle 1.
  - Frame length F = 22*HALF_PERIOD cycles.
  - Frame 2 ends at cycle 3F + 2*GAP_CYCLES.
  - In the following cycle: done_out=1, ready_out=1, lines high.
  - A new request may be accepted on that same cycle's edge, so back-to-back events have no extra gap.
- Counters: timer 16 bits, bit_idx 0..10, frame_idx 0..2. The timer reloads at every phase change; no counter wraps during normal operation.
- done_out and err_out are never high together; each is high for at most one cycle per event.

Test Plan:
- HALF_PERIOD=4, GAP_CYCLES=8, digit 1: frames 16 (bits 0,0,1,1,0,1,0,0,0,parity 0,1), F0 (parity 1), 16.
  - ps2_clk low phases at cycles 5-8, 13-16, ...
  - done_out pulse and ready_out=1 at cycle 281; decode via PS/2 receiver + LUT gives digit 1.
- Sweep digits 0..9 back-to-back with digit_valid held high: each event decodes correctly, parity is odd on every frame, and exactly 10 done_out pulses occur.
- digit_in=4'hC with valid: err_out=1 for one cycle, lines stay high for 50 cycles, ready_out stays 1, no done_out.
- Assert rst during bit 5 of frame 1 (the F0 frame): next cycle lines=1, ready_out=1, no done_out; a new digit 7 request then sends 3D, F0, 3D cleanly.
- Change digit_in and pulse digit_valid while busy: transmitted code is unchanged, no err_out.
- Checker on every run: data never changes while ps2_clk_out=0; each clock high and low phase lasts exactly HALF_PERIOD cycles.
